// File: rtl/pwm_multich_gen.sv
// N-channel PWM generator: prescaled shared carrier (up/down/up-down/freeze), shadowed
// period/compare, per-channel complementary outputs with dead time, and an event-count interrupt.
module pwm_multich_gen #(
    parameter int CNT_W = 16,
    parameter int N_CH  = 4,
    parameter int DT_W  = 10,
    parameter int DIV_W = 16,
    parameter int EVT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [CNT_W-1:0]      period,
    input  logic [CNT_W-1:0]      init_carr,
    input  logic [N_CH*CNT_W-1:0] compare,
    input  logic [DT_W-1:0]       dtime_a,
    input  logic [DT_W-1:0]       dtime_b,
    input  logic [DIV_W-1:0]      clk_div,
    input  logic [1:0]            count_mode,
    input  logic [1:0]            load_mode,
    input  logic                  int_en,
    input  logic [EVT_W-1:0]      event_cnt,
    input  logic                  pol_a,
    input  logic                  pol_b,
    output logic [N_CH-1:0]       pwm_a,
    output logic [N_CH-1:0]       pwm_b,
    output logic [CNT_W-1:0]      carrier,
    output logic                  interrupt
);

    typedef enum logic [2:0] {OFF_AB, DLY_A, ON_A, DLY_B, ON_B} dt_state_t;

    logic [DIV_W-1:0]      div_cnt;
    logic                  tick, zero_evt, period_evt, load_now;
    logic [CNT_W-1:0]      act_period;
    logic [N_CH*CNT_W-1:0] act_cmp;
    logic [CNT_W-1:0]      carr_nxt;
    logic                  dir_up, dir_nxt;
    logic [EVT_W-1:0]      evt_cnt;
    logic [N_CH-1:0]       raw_p1;

    // Stage 0: prescaler, carrier and shadow registers
    assign tick       = en && (div_cnt == clk_div);
    assign zero_evt   = tick && (count_mode != 2'd3) && (carrier == '0);
    assign period_evt = tick && (count_mode != 2'd3) && (carrier == act_period);

    always_comb begin
        case (load_mode)
            2'd0:    load_now = zero_evt;
            2'd1:    load_now = period_evt;
            2'd2:    load_now = zero_evt || period_evt;
            default: load_now = 1'b1;
        endcase
        if (!en)
            load_now = 1'b1;
    end

    always_comb begin
        carr_nxt = carrier;
        dir_nxt  = dir_up;
        if (!en) begin
            carr_nxt = (init_carr < period) ? init_carr : period;
            dir_nxt  = 1'b1;
        end else if (tick) begin
            if (act_period == '0) begin
                carr_nxt = '0;
            end else begin
                case (count_mode)
                    2'd0: carr_nxt = (carrier >= act_period) ? '0 : carrier + CNT_W'(1);
                    2'd1: carr_nxt = (carrier == '0 || carrier > act_period) ? act_period
                                                                             : carrier - CNT_W'(1);
                    2'd2: begin
                        // Endpoints are visited once; the direction flips on leaving them.
                        if (carrier > act_period) begin
                            carr_nxt = act_period;
                            dir_nxt  = 1'b0;
                        end else if (dir_up) begin
                            carr_nxt = (carrier == act_period) ? carrier - CNT_W'(1) : carrier + CNT_W'(1);
                            dir_nxt  = (carrier != act_period);
                        end else begin
                            carr_nxt = (carrier == '0) ? carrier + CNT_W'(1) : carrier - CNT_W'(1);
                            dir_nxt  = (carrier == '0);
                        end
                    end
                    default: carr_nxt = carrier;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt    <= '0;
            carrier    <= '0;
            dir_up     <= 1'b1;
            act_period <= '0;
            act_cmp    <= '0;
        end else begin
            div_cnt <= (!en || tick) ? '0 : div_cnt + DIV_W'(1);
            carrier <= carr_nxt;
            dir_up  <= dir_nxt;
            if (load_now) begin
                act_period <= period;
                act_cmp    <= compare;
            end
        end
    end

    // Stage 1: compare result and interrupt
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            raw_p1 <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++)
                raw_p1[i] <= (carrier < act_cmp[i*CNT_W +: CNT_W]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_cnt   <= '0;
            interrupt <= 1'b0;
        end else if (!en || !int_en) begin
            evt_cnt   <= '0;
            interrupt <= 1'b0;
        end else if (zero_evt) begin
            interrupt <= (evt_cnt == event_cnt);
            evt_cnt   <= (evt_cnt == event_cnt) ? '0 : evt_cnt + EVT_W'(1);
        end else begin
            interrupt <= 1'b0;
        end
    end

    // Stage 2: dead-time FSMs drive the registered pins
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        dt_state_t       st;
        logic [DT_W-1:0] dcnt;
        logic [DT_W:0]   dcnt_inc;
        logic            a_q, b_q;

        assign dcnt_inc = {1'b0, dcnt} + {{DT_W{1'b0}}, 1'b1};
        assign pwm_a[i] = a_q;
        assign pwm_b[i] = b_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                st   <= OFF_AB;
                dcnt <= '0;
                a_q  <= 1'b0;
                b_q  <= 1'b0;
            end else if (!en) begin
                st   <= OFF_AB;
                dcnt <= '0;
                a_q  <= ~pol_a;
                b_q  <= ~pol_b;
            end else begin
                a_q  <= ~pol_a;
                b_q  <= ~pol_b;
                dcnt <= '0;
                if (raw_p1[i] && (st == OFF_AB || st == DLY_B || st == ON_B)) begin
                    st <= (dtime_a == '0) ? ON_A : DLY_A;
                    if (dtime_a == '0)
                        a_q <= pol_a;
                end else if (!raw_p1[i] && (st == OFF_AB || st == DLY_A || st == ON_A)) begin
                    st <= (dtime_b == '0) ? ON_B : DLY_B;
                    if (dtime_b == '0)
                        b_q <= pol_b;
                end else begin
                    case (st)
                        DLY_A: begin
                            if (dcnt_inc >= {1'b0, dtime_a}) begin
                                st  <= ON_A;
                                a_q <= pol_a;
                            end else begin
                                dcnt <= dcnt_inc[DT_W-1:0];
                            end
                        end
                        ON_A: a_q <= pol_a;
                        DLY_B: begin
                            if (dcnt_inc >= {1'b0, dtime_b}) begin
                                st  <= ON_B;
                                b_q <= pol_b;
                            end else begin
                                dcnt <= dcnt_inc[DT_W-1:0];
                            end
                        end
                        ON_B: b_q <= pol_b;
                        default: st <= OFF_AB;
                    endcase
                end
            end
        end
    end

endmodule
